// File: rtl/rs_cw_scheduler_if.sv
// Frame-in / codeword-out handshake bundle for rs_cw_scheduler.
// The slave modport is the scheduler's view; the master modport is the mapper/encoder side.
interface rs_cw_scheduler_if #(
  parameter int unsigned WIDTH_WORD_RS = 5440
);
  logic                     i_valid;
  logic [WIDTH_WORD_RS-1:0] i_word_a;
  logic [WIDTH_WORD_RS-1:0] i_word_b;
  logic [WIDTH_WORD_RS-1:0] i_word_c;
  logic [WIDTH_WORD_RS-1:0] i_word_d;
  logic                     o_in_ready;
  logic                     o_valid;
  logic                     enc_ready;
  logic [WIDTH_WORD_RS-1:0] o_word;
  logic [1:0]               o_cw_idx;
  logic                     o_frame_last;

  modport slave (
    input  i_valid, i_word_a, i_word_b, i_word_c, i_word_d, enc_ready,
    output o_in_ready, o_valid, o_word, o_cw_idx, o_frame_last
  );

  modport master (
    output i_valid, i_word_a, i_word_b, i_word_c, i_word_d, enc_ready,
    input  o_in_ready, o_valid, o_word, o_cw_idx, o_frame_last
  );
endinterface

// File: rtl/rs_cw_scheduler.sv
// Buffers whole 4-codeword frames and issues them one codeword at a time to a shared RS(544,514) encoder.
// Optional RS_SCHED_STATS_EN adds saturating sent/dropped frame counters.
module rs_cw_scheduler #(
  parameter int unsigned WIDTH_WORD_RS = 5440,
  parameter int unsigned NUM_CW        = 4,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rs_cw_scheduler_if.slave      bus,
  input  logic                  clr_ovf,
  output logic                  o_ovf
`ifdef RS_SCHED_STATS_EN
  ,
  output logic [31:0]           o_frames_sent,
  output logic [15:0]           o_frames_dropped
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic [1:0]               sub_idx;
  logic                     valid;
  logic                     pop;
  logic                     pop_last;
  logic                     push;
  logic                     drop;
  logic                     in_ready;

  logic [WIDTH_WORD_RS-1:0] mem [FIFO_DEPTH][NUM_CW];

  // Handshake qualifiers; in_ready looks through enc_ready so a full FIFO
  // can refill in the same cycle its head frame retires.
  always_comb begin
    valid      = (state == SEND);
    pop        = valid && bus.enc_ready;
    pop_last   = pop && (sub_idx == 2'd3);
    in_ready   = (count < CNT_W'(FIFO_DEPTH)) || pop_last;
    push       = bus.i_valid && in_ready;
    drop       = bus.i_valid && !in_ready;
    count_next = count + CNT_W'(push) - CNT_W'(pop_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    bus.o_valid      = 1'b0;
    bus.o_word       = '0;
    bus.o_cw_idx     = sub_idx;
    bus.o_frame_last = (sub_idx == 2'd3);
    bus.o_in_ready   = in_ready;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = SEND;
        end
      end
      SEND: begin
        bus.o_valid = 1'b1;
        bus.o_word  = mem[rd_ptr][sub_idx];
        if (pop_last && (count_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      sub_idx <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        sub_idx <= sub_idx + 2'd1;
      end
      if (pop_last) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Frame storage carries no reset; empty slots are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr][0] <= bus.i_word_a;
      mem[wr_ptr][1] <= bus.i_word_b;
      mem[wr_ptr][2] <= bus.i_word_c;
      mem[wr_ptr][3] <= bus.i_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_ovf <= 1'b0;
    end else if (drop) begin
      o_ovf <= 1'b1;
    end else if (clr_ovf) begin
      o_ovf <= 1'b0;
    end
  end

`ifdef RS_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_frames_sent    <= '0;
      o_frames_dropped <= '0;
    end else begin
      if (pop_last && (o_frames_sent != '1)) begin
        o_frames_sent <= o_frames_sent + 32'd1;
      end
      if (drop && (o_frames_dropped != '1)) begin
        o_frames_dropped <= o_frames_dropped + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_cw_scheduler.sv
// Directed vector bench for rs_cw_scheduler: one table row per clock cycle.
module tb_rs_cw_scheduler;
  localparam int unsigned W = 5440;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] tag;
    logic       er;
    logic       clr;
    logic       rdy;
    logic       val;
    logic [1:0] idx;
    logic       last;
    logic       ovf;
    logic [7:0] wtag;
  } vec_t;

  logic clk;
  logic rst;
  logic clr_ovf;
  logic o_ovf;
`ifdef RS_SCHED_STATS_EN
  logic [31:0] o_frames_sent;
  logic [15:0] o_frames_dropped;
`endif

  int errors;
  int checks;
  vec_t vecs[$];

  rs_cw_scheduler_if #(.WIDTH_WORD_RS(W)) bus ();

  rs_cw_scheduler #(
    .WIDTH_WORD_RS(W),
    .NUM_CW(4),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .clr_ovf(clr_ovf),
    .o_ovf(o_ovf)
`ifdef RS_SCHED_STATS_EN
    ,
    .o_frames_sent(o_frames_sent),
    .o_frames_dropped(o_frames_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [7:0] b);
    mk = {680{b}};
  endfunction

  task automatic v(input logic r, input logic iv, input logic [3:0] tag, input logic er,
                   input logic clr, input logic rdy, input logic val, input logic [1:0] idx,
                   input logic last, input logic ovf, input logic [7:0] wtag);
    vec_t e;
    e.rst = r; e.iv = iv; e.tag = tag; e.er = er; e.clr = clr;
    e.rdy = rdy; e.val = val; e.idx = idx; e.last = last; e.ovf = ovf; e.wtag = wtag;
    vecs.push_back(e);
  endtask

  task automatic chk1(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_ovf = 1'b0;
    bus.i_valid = 1'b0;
    bus.enc_ready = 1'b0;
    bus.i_word_a = '0;
    bus.i_word_b = '0;
    bus.i_word_c = '0;
    bus.i_word_d = '0;
    errors = 0;
    checks = 0;

    //  rst iv tag er clr | rdy val idx last ovf word
    v(0, 0, 4'h0, 0, 0,   1, 0, 0, 0, 0, 8'h00); // reset state
    // single frame, enc_ready=1
    v(0, 1, 4'h0, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   1, 1, 0, 0, 0, 8'h01);
    v(0, 0, 4'h0, 1, 0,   1, 1, 1, 0, 0, 8'h02);
    v(0, 0, 4'h0, 1, 0,   1, 1, 2, 0, 0, 8'h03);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 0, 8'h04);
    v(0, 0, 4'h0, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    // three frames, third dropped, then drain without bubble
    v(0, 1, 4'h1, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'h2, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'h3, 0, 0,   0, 1, 0, 0, 0, 8'h11);
    v(0, 0, 4'h0, 1, 0,   0, 1, 0, 0, 1, 8'h11);
    v(0, 0, 4'h0, 1, 0,   0, 1, 1, 0, 1, 8'h12);
    v(0, 0, 4'h0, 1, 0,   0, 1, 2, 0, 1, 8'h13);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 1, 8'h14);
    v(0, 0, 4'h0, 1, 0,   1, 1, 0, 0, 1, 8'h21);
    v(0, 0, 4'h0, 1, 0,   1, 1, 1, 0, 1, 8'h22);
    v(0, 0, 4'h0, 1, 0,   1, 1, 2, 0, 1, 8'h23);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 1, 8'h24);
    v(0, 0, 4'h0, 0, 1,   1, 0, 0, 0, 1, 8'h00);
    // stall pattern 1,0,0,1 mid-frame
    v(0, 1, 4'h4, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   1, 1, 0, 0, 0, 8'h41);
    v(0, 0, 4'h0, 0, 0,   1, 1, 1, 0, 0, 8'h42);
    v(0, 0, 4'h0, 0, 0,   1, 1, 1, 0, 0, 8'h42);
    v(0, 0, 4'h0, 1, 0,   1, 1, 1, 0, 0, 8'h42);
    v(0, 0, 4'h0, 1, 0,   1, 1, 2, 0, 0, 8'h43);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 0, 8'h44);
    v(0, 0, 4'h0, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    // full FIFO accepts a frame on pop_last of D
    v(0, 1, 4'h5, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'h6, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   0, 1, 0, 0, 0, 8'h51);
    v(0, 0, 4'h0, 1, 0,   0, 1, 1, 0, 0, 8'h52);
    v(0, 0, 4'h0, 1, 0,   0, 1, 2, 0, 0, 8'h53);
    v(0, 1, 4'h7, 1, 0,   1, 1, 3, 1, 0, 8'h54);
    v(0, 0, 4'h0, 0, 0,   0, 1, 0, 0, 0, 8'h61);
    v(0, 0, 4'h0, 1, 0,   0, 1, 0, 0, 0, 8'h61);
    v(0, 0, 4'h0, 1, 0,   0, 1, 1, 0, 0, 8'h62);
    v(0, 0, 4'h0, 1, 0,   0, 1, 2, 0, 0, 8'h63);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 0, 8'h64);
    v(0, 0, 4'h0, 1, 0,   1, 1, 0, 0, 0, 8'h71);
    v(0, 0, 4'h0, 1, 0,   1, 1, 1, 0, 0, 8'h72);
    v(0, 0, 4'h0, 1, 0,   1, 1, 2, 0, 0, 8'h73);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 0, 8'h74);
    v(0, 0, 4'h0, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    // reset while idx==2 discards partial and queued frames
    v(0, 1, 4'h8, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'h9, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   0, 1, 0, 0, 0, 8'h81);
    v(0, 0, 4'h0, 1, 0,   0, 1, 1, 0, 0, 8'h82);
    v(1, 0, 4'h0, 1, 0,   0, 1, 2, 0, 0, 8'h83);
    v(0, 0, 4'h0, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'hA, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 0, 4'h0, 1, 0,   1, 1, 0, 0, 0, 8'hA1);
    v(0, 0, 4'h0, 1, 0,   1, 1, 1, 0, 0, 8'hA2);
    v(0, 0, 4'h0, 1, 0,   1, 1, 2, 0, 0, 8'hA3);
    v(0, 0, 4'h0, 1, 0,   1, 1, 3, 1, 0, 8'hA4);
    v(0, 0, 4'h0, 1, 0,   1, 0, 0, 0, 0, 8'h00);
    // drop with simultaneous clr_ovf: set wins, then clr alone clears
    v(0, 1, 4'hB, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'hC, 0, 0,   1, 0, 0, 0, 0, 8'h00);
    v(0, 1, 4'hD, 0, 1,   0, 1, 0, 0, 0, 8'hB1);
    v(0, 0, 4'h0, 0, 1,   0, 1, 0, 0, 1, 8'hB1);
    v(0, 0, 4'h0, 0, 0,   0, 1, 0, 0, 0, 8'hB1);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      clr_ovf       = vecs[i].clr;
      bus.enc_ready = vecs[i].er;
      bus.i_valid   = vecs[i].iv;
      bus.i_word_a  = mk({vecs[i].tag, 4'h1});
      bus.i_word_b  = mk({vecs[i].tag, 4'h2});
      bus.i_word_c  = mk({vecs[i].tag, 4'h3});
      bus.i_word_d  = mk({vecs[i].tag, 4'h4});
      #1;
      chk1("in_ready", i, {7'd0, bus.o_in_ready}, {7'd0, vecs[i].rdy});
      chk1("valid", i, {7'd0, bus.o_valid}, {7'd0, vecs[i].val});
      chk1("cw_idx", i, {6'd0, bus.o_cw_idx}, {6'd0, vecs[i].idx});
      chk1("frame_last", i, {7'd0, bus.o_frame_last}, {7'd0, vecs[i].last});
      chk1("ovf", i, {7'd0, o_ovf}, {7'd0, vecs[i].ovf});
      checks++;
      if (bus.o_word !== mk(vecs[i].wtag)) begin
        errors++;
        $display("FAIL row %0d word: got low byte %0h high byte %0h expected %0h",
                 i, bus.o_word[7:0], bus.o_word[W-1 -: 8], vecs[i].wtag);
      end
    end

`ifdef RS_SCHED_STATS_EN
    // since the mid-frame reset: frame A sent, frame D dropped
    checks++;
    if (o_frames_sent !== 32'd1) begin
      errors++;
      $display("FAIL frames_sent: got %0d expected 1", o_frames_sent);
    end
    checks++;
    if (o_frames_dropped !== 16'd1) begin
      errors++;
      $display("FAIL frames_dropped: got %0d expected 1", o_frames_dropped);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
